// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache controller.
// Holds the controller state encoding, the address field positions and the
// line, word and RAM geometry constants. These are used by dcache_ctrl and
// dcache_merge.
package dcache_pkg;

    localparam int IDX_W    = 5;                 // set index width (32 sets)
    localparam int TAG_W    = 7;                 // tag width
    localparam int LINE_W   = 128;               // line width in bits
    localparam int WORD_W   = 32;                // core word width
    localparam int ADDR_W   = 16;                // core byte address width
    localparam int NSETS    = 1 << IDX_W;
    localparam int LBYTES   = LINE_W / 8;        // bytes per line
    localparam int MADDR_W  = TAG_W + IDX_W;     // OCM line address width

    // Byte address layout: tag[15:9] | index[8:4] | word[3:2] | byte[1:0]
    localparam int TAG_LSB  = 9;
    localparam int IDX_LSB  = 4;
    localparam int WORD_LSB = 2;

    // RF_REQ is a reserved encoding that is never entered.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOOKUP  = 3'd1,
        ST_WB      = 3'd2,
        ST_RF_REQ  = 3'd3,
        ST_FILL    = 3'd4,
        ST_FL_RD   = 3'd5,
        ST_FL_CHK  = 3'd6,
        ST_FL_DONE = 3'd7
    } state_t;

endpackage

// File: rtl/dcache_merge.sv
// Combinational store merge and load word select for one cache line.
// Ports:
//   line_in  : line to merge into (data RAM read or OCM fill data)
//   word_sel : word within the line (addr[3:2])
//   wdata/be : store data and byte enables
//   we       : 1 for a store; with we = 0 the line passes through unchanged
//   line_out : line with the store bytes merged in
//   byte_en  : per-byte mask of the lanes written by the store (active high)
//   word_out : the selected 32-bit word of line_out
module dcache_merge
    import dcache_pkg::*;
(
    input  logic [LINE_W-1:0] line_in,
    input  logic [1:0]        word_sel,
    input  logic [WORD_W-1:0] wdata,
    input  logic [3:0]        be,
    input  logic              we,
    output logic [LINE_W-1:0] line_out,
    output logic [LBYTES-1:0] byte_en,
    output logic [WORD_W-1:0] word_out
);

    genvar gi;
    generate
        for (gi = 0; gi < LBYTES; gi++) begin : g_byte
            // Byte gi belongs to word gi/4, lane gi%4.
            assign byte_en[gi] = we && (word_sel == 2'(gi / 4)) && be[gi % 4];
            assign line_out[gi*8 +: 8] = byte_en[gi] ? wdata[(gi % 4)*8 +: 8]
                                                     : line_in[gi*8 +: 8];
        end
    endgenerate

    assign word_out = line_out[{word_sel, 5'd0} +: WORD_W];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// It has 32 sets of 16-byte lines and uses 16-bit byte addresses.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_* / resp_*        : core load/store request and one-cycle response
//   flush_req/flush_done  : write back + invalidate all sets, done pulse
//   tag_*                 : tag RAM macro (port A read, port B write), active-low enables
//   dm_*                  : data RAM macro, active-low enable and byte write enables
//   mem_*                 : OCM port B, line addressed, active-low enable/write
// Valid and dirty bits are held in flops because the RAM macros are not reset.
// All RAM controls and the response are decoded combinationally from the state.
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [WORD_W-1:0]   req_wdata,
    input  logic [3:0]          req_be,
    output logic                resp_valid,
    output logic [WORD_W-1:0]   resp_rdata,
    input  logic                flush_req,
    output logic                flush_done,
    output logic                tag_cena,
    output logic [IDX_W-1:0]    tag_aa,
    input  logic [TAG_W-1:0]    tag_qa,
    output logic                tag_cenb,
    output logic [IDX_W-1:0]    tag_ab,
    output logic [TAG_W-1:0]    tag_db,
    output logic                dm_cen,
    output logic [LBYTES-1:0]   dm_wen,
    output logic [IDX_W-1:0]    dm_a,
    output logic [LINE_W-1:0]   dm_d,
    input  logic [LINE_W-1:0]   dm_q,
    output logic                mem_cen,
    output logic                mem_wen,
    output logic [MADDR_W-1:0]  mem_addr,
    output logic [LINE_W-1:0]   mem_wdata,
    input  logic [LINE_W-1:0]   mem_rdata
);

    state_t             state_reg;
    logic [NSETS-1:0]   valid_reg;
    logic [NSETS-1:0]   dirty_reg;
    logic [IDX_W-1:0]   fl_idx_reg;
    logic               we_reg;
    logic [TAG_W-1:0]   tag_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [1:0]         word_reg;
    logic [WORD_W-1:0]  wdata_reg;
    logic [3:0]         be_reg;

    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   req_idx;
    logic               unused_addr_bits;
    logic               accept;
    logic               hit;
    logic               evict;
    logic               fl_dirty;
    logic [LINE_W-1:0]  merge_base;
    logic [LINE_W-1:0]  merged_line;
    logic [LBYTES-1:0]  merge_be;
    logic [WORD_W-1:0]  merged_word;

    assign req_tag          = req_addr[ADDR_W-1:TAG_LSB];
    assign req_idx          = req_addr[TAG_LSB-1:IDX_LSB];
    assign unused_addr_bits = &{1'b0, req_addr[WORD_LSB-1:0]};

    // A flush request takes priority: the request is left waiting in IDLE.
    assign accept   = (state_reg == ST_IDLE) && req_valid && !flush_req;
    assign hit      = valid_reg[idx_reg] && (tag_qa == tag_reg);
    assign evict    = valid_reg[idx_reg] && dirty_reg[idx_reg];
    assign fl_dirty = valid_reg[fl_idx_reg] && dirty_reg[fl_idx_reg];

    // A write hit merges into the line just read from the data RAM.
    // A fill merges into the line returned by the OCM.
    assign merge_base = (state_reg == ST_FILL) ? mem_rdata : dm_q;

    dcache_merge u_merge (
        .line_in  (merge_base),
        .word_sel (word_reg),
        .wdata    (wdata_reg),
        .be       (be_reg),
        .we       (we_reg),
        .line_out (merged_line),
        .byte_en  (merge_be),
        .word_out (merged_word)
    );

    always_comb begin
        req_ready  = (state_reg == ST_IDLE);
        resp_valid = 1'b0;
        resp_rdata = '0;
        flush_done = 1'b0;
        tag_cena   = 1'b1;
        tag_aa     = '0;
        tag_cenb   = 1'b1;
        tag_ab     = '0;
        tag_db     = '0;
        dm_cen     = 1'b1;
        dm_wen     = '1;
        dm_a       = '0;
        dm_d       = '0;
        mem_cen    = 1'b1;
        mem_wen    = 1'b1;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    tag_cena = 1'b0;
                    tag_aa   = req_idx;
                    dm_cen   = 1'b0;
                    dm_a     = req_idx;
                end
            end
            ST_LOOKUP: begin
                if (hit) begin
                    resp_valid = 1'b1;
                    if (we_reg) begin
                        dm_cen = 1'b0;
                        dm_wen = ~merge_be;
                        dm_a   = idx_reg;
                        dm_d   = merged_line;
                    end else begin
                        resp_rdata = merged_word;
                    end
                end else if (evict) begin
                    mem_cen   = 1'b0;
                    mem_wen   = 1'b0;
                    mem_addr  = {tag_qa, idx_reg};
                    mem_wdata = dm_q;
                end else begin
                    mem_cen  = 1'b0;
                    mem_addr = {tag_reg, idx_reg};
                end
            end
            ST_WB: begin
                mem_cen  = 1'b0;
                mem_addr = {tag_reg, idx_reg};
            end
            ST_FILL: begin
                dm_cen     = 1'b0;
                dm_wen     = '0;
                dm_a       = idx_reg;
                dm_d       = merged_line;
                tag_cenb   = 1'b0;
                tag_ab     = idx_reg;
                tag_db     = tag_reg;
                resp_valid = 1'b1;
                resp_rdata = merged_word;
            end
            ST_FL_RD: begin
                tag_cena = 1'b0;
                tag_aa   = fl_idx_reg;
                dm_cen   = 1'b0;
                dm_a     = fl_idx_reg;
            end
            ST_FL_CHK: begin
                if (fl_dirty) begin
                    mem_cen   = 1'b0;
                    mem_wen   = 1'b0;
                    mem_addr  = {tag_qa, fl_idx_reg};
                    mem_wdata = dm_q;
                end
            end
            ST_FL_DONE: flush_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            valid_reg  <= '0;
            dirty_reg  <= '0;
            fl_idx_reg <= '0;
            we_reg     <= 1'b0;
            tag_reg    <= '0;
            idx_reg    <= '0;
            word_reg   <= '0;
            wdata_reg  <= '0;
            be_reg     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (flush_req) begin
                        state_reg <= ST_FL_RD;
                    end else if (req_valid) begin
                        we_reg    <= req_we;
                        tag_reg   <= req_tag;
                        idx_reg   <= req_idx;
                        word_reg  <= req_addr[IDX_LSB-1:WORD_LSB];
                        wdata_reg <= req_wdata;
                        be_reg    <= req_be;
                        state_reg <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (hit) begin
                        if (we_reg) dirty_reg[idx_reg] <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else if (evict) begin
                        state_reg <= ST_WB;
                    end else begin
                        state_reg <= ST_FILL;
                    end
                end
                ST_WB:   state_reg <= ST_FILL;
                ST_FILL: begin
                    valid_reg[idx_reg] <= 1'b1;
                    dirty_reg[idx_reg] <= we_reg;
                    state_reg          <= ST_IDLE;
                end
                ST_FL_RD: state_reg <= ST_FL_CHK;
                ST_FL_CHK: begin
                    valid_reg[fl_idx_reg] <= 1'b0;
                    dirty_reg[fl_idx_reg] <= 1'b0;
                    if (fl_idx_reg == IDX_W'(NSETS - 1)) begin
                        state_reg <= ST_FL_DONE;
                    end else begin
                        fl_idx_reg <= fl_idx_reg + 1'b1;
                        state_reg  <= ST_FL_RD;
                    end
                end
                ST_FL_DONE: begin
                    fl_idx_reg <= '0;
                    state_reg  <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
`timescale 1ns/1ps
module tb_dcache_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid, req_ready, req_we;
    logic [15:0]  req_addr;
    logic [31:0]  req_wdata;
    logic [3:0]   req_be;
    logic         resp_valid;
    logic [31:0]  resp_rdata;
    logic         flush_req, flush_done;
    logic         tag_cena, tag_cenb;
    logic [4:0]   tag_aa, tag_ab;
    logic [6:0]   tag_qa, tag_db;
    logic         dm_cen;
    logic [15:0]  dm_wen;
    logic [4:0]   dm_a;
    logic [127:0] dm_d, dm_q;
    logic         mem_cen, mem_wen;
    logic [11:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .flush_req(flush_req), .flush_done(flush_done),
        .tag_cena(tag_cena), .tag_aa(tag_aa), .tag_qa(tag_qa),
        .tag_cenb(tag_cenb), .tag_ab(tag_ab), .tag_db(tag_db),
        .dm_cen(dm_cen), .dm_wen(dm_wen), .dm_a(dm_a), .dm_d(dm_d), .dm_q(dm_q),
        .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // RAM macro models (read latency 1) and OCM traffic log
    logic [6:0]   tag_mem [32];
    logic [127:0] dm_mem  [32];
    logic [127:0] ocm_mem [4096];
    logic [11:0]  wr_addr_q [$];
    logic [127:0] wr_data_q [$];
    logic [11:0]  rd_addr_q [$];

    always @(posedge clk) begin
        if (!tag_cena) tag_qa <= tag_mem[tag_aa];
        if (!tag_cenb) tag_mem[tag_ab] <= tag_db;
        if (!dm_cen) begin
            dm_q <= dm_mem[dm_a];
            for (int b = 0; b < 16; b++)
                if (!dm_wen[b]) dm_mem[dm_a][b*8 +: 8] <= dm_d[b*8 +: 8];
        end
        if (!mem_cen) begin
            if (!mem_wen) begin
                ocm_mem[mem_addr] <= mem_wdata;
                wr_addr_q.push_back(mem_addr);
                wr_data_q.push_back(mem_wdata);
            end else begin
                mem_rdata <= ocm_mem[mem_addr];
                rd_addr_q.push_back(mem_addr);
            end
        end
    end

    // Reference model: architectural memory plus per-set cache bookkeeping
    logic [127:0] ref_mem [4096];
    logic [31:0]  ref_valid, ref_dirty;
    logic [6:0]   ref_tag [32];
    logic [11:0]  exp_fl_q [$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic ref_reset();
        ref_valid = '0;
        ref_dirty = '0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = ocm_mem[i];
    endtask

    task automatic ref_access(input logic we, input logic [15:0] addr,
                              input logic [31:0] wd, input logic [3:0] be,
                              output int lat, output logic [31:0] rdata,
                              output int n_wb, output logic [11:0] wb_addr,
                              output logic [127:0] wb_data,
                              output int n_rd, output logic [11:0] rd_addr);
        int idx, w;
        logic [6:0]  tag;
        logic [11:0] line;
        idx = int'(addr[8:4]);
        w   = int'(addr[3:2]);
        tag = addr[15:9];
        line = addr[15:4];
        n_wb = 0; n_rd = 0; wb_addr = '0; wb_data = '0; rd_addr = '0;
        if (ref_valid[idx] && ref_tag[idx] == tag) begin
            lat = 1;
        end else begin
            if (ref_valid[idx] && ref_dirty[idx]) begin
                n_wb    = 1;
                wb_addr = {ref_tag[idx], 5'(idx)};
                wb_data = ref_mem[wb_addr];
                lat     = 3;
            end else begin
                lat = 2;
            end
            n_rd = 1;
            rd_addr = line;
            ref_valid[idx] = 1'b1;
            ref_dirty[idx] = 1'b0;
            ref_tag[idx]   = tag;
        end
        if (we) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[line][(w*4 + b)*8 +: 8] = wd[b*8 +: 8];
            ref_dirty[idx] = 1'b1;
        end
        rdata = ref_mem[line][w*32 +: 32];
    endtask

    task automatic ref_flush();
        exp_fl_q.delete();
        for (int s = 0; s < 32; s++)
            if (ref_valid[s] && ref_dirty[s]) exp_fl_q.push_back({ref_tag[s], 5'(s)});
        ref_valid = '0;
        ref_dirty = '0;
    endtask

    // Drivers: entered and left at #1 after a rising edge with the DUT idle
    task automatic do_req(input logic we, input logic [15:0] addr,
                          input logic [31:0] wd, input logic [3:0] be,
                          output int lat, output logic [31:0] rd, output logic [15:0] wen);
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; rd = '0; wen = '1;
        for (int n = 1; n <= 10; n++) begin
            if (resp_valid) begin
                lat = n; rd = resp_rdata; wen = dm_wen;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_flush(output int done_at);
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
        flush_req = 1'b1;
        @(posedge clk); #1;
        flush_req = 1'b0;
        done_at = 0;
        for (int n = 1; n <= 100; n++) begin
            if (flush_done) begin
                done_at = n;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        flush_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        ref_reset();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        flush_req = 1'b0;
        #12;
        n_tests++; if (resp_valid !== 1'b0 || flush_done !== 1'b0) begin n_fail++;
            $display("FAIL reset_pulses: resp_valid=%b flush_done=%b, want 0 0", resp_valid, flush_done); end
        n_tests++; if (resp_rdata !== 32'h0) begin n_fail++;
            $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
        n_tests++; if ({tag_cena, tag_cenb, dm_cen, mem_cen, mem_wen} !== 5'b11111) begin n_fail++;
            $display("FAIL reset_enables: got %b want 11111", {tag_cena, tag_cenb, dm_cen, mem_cen, mem_wen}); end
        n_tests++; if (dm_wen !== 16'hFFFF) begin n_fail++;
            $display("FAIL reset_dm_wen: got %h want ffff", dm_wen); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        ref_reset();
        n_tests++; if (req_ready !== 1'b1) begin n_fail++;
            $display("FAIL reset_ready: got %b want 1", req_ready); end
        $display("[TB] reset checked");
    endtask

    task automatic test_cold_miss();
        int lat, elat, nwb, nrd; logic [31:0] rd, erd; logic [15:0] wen;
        logic [11:0] wba, rda; logic [127:0] wbd;
        ref_access(1'b0, 16'h1234, '0, '0, elat, erd, nwb, wba, wbd, nrd, rda);
        do_req(1'b0, 16'h1234, '0, '0, lat, rd, wen);
        $display("[TB] load 1234: lat=%0d data=%h", lat, rd);
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL cold_lat: got %0d want 2", lat); end
        n_tests++; if (rd !== erd) begin n_fail++; $display("FAIL cold_data: got %h want %h", rd, erd); end
        n_tests++; if (rd_addr_q.size() != 1 || wr_addr_q.size() != 0 || rd_addr_q[0] !== 12'h123) begin n_fail++;
            $display("FAIL cold_ocm: reads=%0d writes=%0d want 1 read of 123", rd_addr_q.size(), wr_addr_q.size()); end
        // Another word of the same line must now hit.
        ref_access(1'b0, 16'h1230, '0, '0, elat, erd, nwb, wba, wbd, nrd, rda);
        do_req(1'b0, 16'h1230, '0, '0, lat, rd, wen);
        $display("[TB] load 1230: lat=%0d data=%h", lat, rd);
        n_tests++; if (lat !== 1 || rd !== erd) begin n_fail++;
            $display("FAIL cold_rehit: lat=%0d data=%h want lat 1 data %h", lat, rd, erd); end
    endtask

    task automatic test_store_hit();
        int lat, elat, nwb, nrd; logic [31:0] rd, erd; logic [15:0] wen;
        logic [11:0] wba, rda; logic [127:0] wbd;
        ref_access(1'b1, 16'h1238, 32'hAABBCCDD, 4'b0101, elat, erd, nwb, wba, wbd, nrd, rda);
        do_req(1'b1, 16'h1238, 32'hAABBCCDD, 4'b0101, lat, rd, wen);
        $display("[TB] store 1238: lat=%0d dm_wen=%h", lat, wen);
        n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL store_lat: got %0d want 1", lat); end
        n_tests++; if (wen !== 16'hFAFF) begin n_fail++; $display("FAIL store_wen: got %h want faff", wen); end
        n_tests++; if (rd_addr_q.size() + wr_addr_q.size() != 0) begin n_fail++;
            $display("FAIL store_ocm: got %0d OCM ops want 0", rd_addr_q.size() + wr_addr_q.size()); end
        ref_access(1'b0, 16'h1238, '0, '0, elat, erd, nwb, wba, wbd, nrd, rda);
        do_req(1'b0, 16'h1238, '0, '0, lat, rd, wen);
        $display("[TB] load 1238: lat=%0d data=%h", lat, rd);
        n_tests++; if (lat !== 1 || rd !== erd) begin n_fail++;
            $display("FAIL store_readback: lat=%0d data=%h want lat 1 data %h", lat, rd, erd); end
    endtask

    task automatic test_dirty_evict();
        int lat, elat, nwb, nrd; logic [31:0] rd, erd; logic [15:0] wen;
        logic [11:0] wba, rda; logic [127:0] wbd;
        ref_access(1'b0, 16'h3234, '0, '0, elat, erd, nwb, wba, wbd, nrd, rda);
        do_req(1'b0, 16'h3234, '0, '0, lat, rd, wen);
        $display("[TB] load 3234: lat=%0d data=%h writes=%0d reads=%0d", lat, rd, wr_addr_q.size(), rd_addr_q.size());
        n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL evict_lat: got %0d want 3", lat); end
        n_tests++; if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 12'h123 || wr_data_q[0] !== wbd) begin n_fail++;
            $display("FAIL evict_wb: writes=%0d want 1 to 123 data %h", wr_addr_q.size(), wbd); end
        n_tests++; if (rd_addr_q.size() != 1 || rd_addr_q[0] !== 12'h323) begin n_fail++;
            $display("FAIL evict_fill: reads=%0d want 1 of 323", rd_addr_q.size()); end
        n_tests++; if (rd !== erd) begin n_fail++; $display("FAIL evict_data: got %h want %h", rd, erd); end
    endtask

    task automatic test_flush();
        int lat, elat, nwb, nrd, done_at, bad; logic [31:0] rd, erd; logic [15:0] wen;
        logic [11:0] wba, rda; logic [127:0] wbd;
        ref_access(1'b1, 16'h0A08, 32'h11223344, 4'b1111, elat, erd, nwb, wba, wbd, nrd, rda);
        do_req(1'b1, 16'h0A08, 32'h11223344, 4'b1111, lat, rd, wen);
        ref_access(1'b1, 16'h01F4, 32'h55667788, 4'b1001, elat, erd, nwb, wba, wbd, nrd, rda);
        do_req(1'b1, 16'h01F4, 32'h55667788, 4'b1001, lat, rd, wen);
        ref_flush();
        do_flush(done_at);
        $display("[TB] flush: done at cycle %0d, %0d writes", done_at, wr_addr_q.size());
        n_tests++; if (done_at !== 65) begin n_fail++; $display("FAIL flush_cycles: got %0d want 65", done_at); end
        n_tests++; if (wr_addr_q.size() != 2 || exp_fl_q.size() != 2) begin n_fail++;
            $display("FAIL flush_count: got %0d writes want 2", wr_addr_q.size()); end
        else for (int i = 0; i < 2; i++) begin
            n_tests++; if (wr_addr_q[i] !== exp_fl_q[i] || wr_data_q[i] !== ref_mem[exp_fl_q[i]]) begin n_fail++;
                $display("FAIL flush_wr%0d: addr %h want %h", i, wr_addr_q[i], exp_fl_q[i]); end
        end
        bad = 0;
        for (int i = 0; i < 4096; i++) if (ocm_mem[i] !== ref_mem[i]) bad++;
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL flush_ocm: %0d lines differ want 0", bad); end
        ref_access(1'b0, 16'h0A08, '0, '0, elat, erd, nwb, wba, wbd, nrd, rda);
        do_req(1'b0, 16'h0A08, '0, '0, lat, rd, wen);
        $display("[TB] load 0a08 after flush: lat=%0d data=%h", lat, rd);
        n_tests++; if (lat !== 2 || rd !== erd) begin n_fail++;
            $display("FAIL flush_invalid: lat=%0d data=%h want lat 2 data %h", lat, rd, erd); end
    endtask

    task automatic test_priority();
        int done_at, resp_at, ready_cnt, elat, nwb, nrd; logic [31:0] rd, erd;
        logic [11:0] wba, rda; logic [127:0] wbd;
        // Line 0a0 is valid beforehand, so an early accept would show as a hit.
        ref_flush();
        ref_access(1'b0, 16'h0A04, '0, '0, elat, erd, nwb, wba, wbd, nrd, rda);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0A04; flush_req = 1'b1;
        @(posedge clk); #1;
        flush_req = 1'b0;
        done_at = 0; resp_at = 0; ready_cnt = 0; rd = '0;
        for (int n = 1; n <= 100; n++) begin
            if (flush_done && done_at == 0) done_at = n;
            if (req_ready && done_at == 0) ready_cnt++;
            if (resp_valid) begin resp_at = n; rd = resp_rdata; break; end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        @(posedge clk); #1;
        $display("[TB] priority: done at %0d, resp at %0d data=%h", done_at, resp_at, rd);
        n_tests++; if (done_at !== 65 || ready_cnt != 0) begin n_fail++;
            $display("FAIL prio_flush: done=%0d ready_cycles=%0d want 65 0", done_at, ready_cnt); end
        n_tests++; if (resp_at !== 66 + elat || rd !== erd) begin n_fail++;
            $display("FAIL prio_req: resp=%0d data=%h want %0d %h", resp_at, rd, 66 + elat, erd); end
    endtask

    task automatic test_random();
        int lat, elat, nwb, nrd, done_at, bad, errs; logic [31:0] rd, erd, wd; logic [15:0] wen, addr;
        logic [11:0] wba, rda; logic [127:0] wbd; logic we; logic [3:0] be;
        errs = 0;
        for (int t = 0; t < 200; t++) begin
            addr = {7'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'b00};
            we   = 1'($urandom_range(0, 1));
            wd   = $urandom;
            be   = 4'($urandom_range(0, 15));
            ref_access(we, addr, wd, be, elat, erd, nwb, wba, wbd, nrd, rda);
            do_req(we, addr, wd, be, lat, rd, wen);
            $display("[TB] rnd %0d: %s %h lat=%0d data=%h", t, we ? "st" : "ld", addr, lat, rd);
            n_tests++; if (lat !== elat || (!we && rd !== erd)) begin n_fail++; errs++;
                $display("FAIL rnd_resp: op %0d lat=%0d data=%h want lat %0d data %h", t, lat, rd, elat, erd); end
            n_tests++; if (wr_addr_q.size() != nwb || rd_addr_q.size() != nrd ||
                           (nwb == 1 && (wr_addr_q[0] !== wba || wr_data_q[0] !== wbd)) ||
                           (nrd == 1 && rd_addr_q[0] !== rda)) begin n_fail++; errs++;
                $display("FAIL rnd_ocm: op %0d writes=%0d reads=%0d want %0d %0d", t, wr_addr_q.size(), rd_addr_q.size(), nwb, nrd); end
            if (errs > 10) break;
        end
        ref_flush();
        do_flush(done_at);
        $display("[TB] random flush: done at %0d, %0d writes", done_at, wr_addr_q.size());
        n_tests++; if (done_at !== 65 || wr_addr_q.size() != exp_fl_q.size()) begin n_fail++;
            $display("FAIL rnd_flush: done=%0d writes=%0d want 65 %0d", done_at, wr_addr_q.size(), exp_fl_q.size()); end
        bad = 0;
        for (int i = 0; i < 4096; i++) if (ocm_mem[i] !== ref_mem[i]) bad++;
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL rnd_ocm_final: %0d lines differ want 0", bad); end
    endtask

    task automatic test_async_reset();
        int lat, elat, nwb, nrd; logic [31:0] rd, erd; logic [15:0] wen;
        logic [11:0] wba, rda; logic [127:0] wbd;
        ref_access(1'b0, 16'h4560, '0, '0, elat, erd, nwb, wba, wbd, nrd, rda);
        do_req(1'b0, 16'h4560, '0, '0, lat, rd, wen);
        // Conflicting load to the same set, killed by reset while in FILL.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'hC560;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (resp_valid !== 1'b1) begin n_fail++;
            $display("FAIL areset_fill: resp_valid=%b want 1 in FILL", resp_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || dm_cen !== 1'b1 || tag_cenb !== 1'b1 ||
                       dm_wen !== 16'hFFFF || mem_cen !== 1'b1) begin n_fail++;
            $display("FAIL areset_outputs: resp_valid=%b rdata=%h dm_cen=%b tag_cenb=%b want 0 0 1 1",
                     resp_valid, resp_rdata, dm_cen, tag_cenb); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        ref_reset();
        ref_access(1'b0, 16'h4560, '0, '0, elat, erd, nwb, wba, wbd, nrd, rda);
        do_req(1'b0, 16'h4560, '0, '0, lat, rd, wen);
        $display("[TB] load 4560 after reset: lat=%0d data=%h", lat, rd);
        n_tests++; if (lat !== 2 || rd !== erd) begin n_fail++;
            $display("FAIL areset_miss: lat=%0d data=%h want lat 2 data %h", lat, rd, erd); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            tag_mem[i] = 7'($urandom);
            dm_mem[i]  = {$urandom, $urandom, $urandom, $urandom};
        end
        for (int i = 0; i < 4096; i++) ocm_mem[i] = {$urandom, $urandom, $urandom, $urandom};
        test_reset();
        test_cold_miss();
        test_store_hit();
        test_dirty_evict();
        test_flush();
        test_priority();
        test_random();
        apply_reset();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, want finish before 500us");
        $fatal(1, "watchdog");
    end

endmodule
